aes_host_driver: RTL and testbench

AES_HOST_DRIVER -- requirements
Module: aes_host_driver

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/define.sv | 17 +
 rtl/aes_host_driver.sv | 169 ++++++++++++++++
 tb/tb_aes_host_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types for the AES host driver: sequencer states, STATUS bit positions
// and the mapping from 32-bit word index to register offset.
package aes_pkg;

  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_VALID_BIT = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR0,
    S_CTRL,
    S_CFG,
    S_KEY,
    S_BLK,
    S_START,
    S_POLL,
    S_RD,
    S_CLR1,
    S_RESP
  } state_t;

  // Word 0 is always bits [127:96]. The peripheral places the words at scrambled offsets.
  function automatic logic [31:0] load_word_offset(input logic [1:0] idx);
    unique case (idx)
      2'd0:    return 32'h0;
      2'd1:    return 32'hC;
      2'd2:    return 32'h8;
      default: return 32'h4;
    endcase
  endfunction

  function automatic logic [31:0] result_word_offset(input logic [1:0] idx);
    unique case (idx)
      2'd0:    return 32'h4;
      2'd1:    return 32'h8;
      2'd2:    return 32'hC;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/define.sv
// AES peripheral register map for slot 0 and the control-bit positions used by the host driver.
`ifndef AES_DEFINE_SV
`define AES_DEFINE_SV

`define ADDR_CTRL        32'h0000_0000
`define ADDR_CONFIG      32'h0000_0004
`define ADDR_STATUS      32'h0000_0008
`define ADDR_START       32'h0000_000C
`define ADDR_KEY0        32'h0000_0010
`define ADDR_BLOCK0      32'h0000_0020
`define ADDR_RESULT0     32'h0000_0030

`define CTRL_ON0_BIT     0
`define CTRL_ENCDEC0_BIT 0
`define START_BIT        0

`endif

// File: rtl/aes_host_driver.sv
// Drives one AES operation on slot 0 of the AES register bus per accepted command
// and returns the 128-bit result, or an error if STATUS.VALID never rises.
`include "define.sv"

module aes_host_driver
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic         cmd_encdec_i,
  input  logic [127:0] cmd_key_i,
  input  logic [127:0] cmd_block_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [127:0] rsp_result_o,
  output logic         rsp_error_o,
  output logic         aes_cs_o,
  output logic         aes_we_o,
  output logic [31:0]  aes_addr_o,
  output logic [31:0]  aes_wdata_o,
  input  logic [31:0]  aes_rdata_i,
  output logic         busy_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         r_state;
  state_t         w_next;
  logic [1:0]     r_word;
  logic [TW-1:0]  r_tmo;
  logic           r_encdec;
  logic [127:0]   r_key;
  logic [127:0]   r_block;
  logic [127:0]   r_result;
  logic           r_error;

  logic           w_accept;
  logic           w_last_word;
  logic           w_poll_valid;
  logic           w_tmo_hit;
  logic [6:0]     w_word_lsb;

  assign w_accept     = cmd_valid_i & cmd_ready_o;
  assign w_last_word  = (r_word == 2'd3);
  assign w_poll_valid = aes_rdata_i[STATUS_VALID_BIT];
  assign w_tmo_hit    = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_word_lsb   = {~r_word, 5'd0};

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CLR0;
      S_CLR0:  w_next = S_CTRL;
      S_CTRL:  w_next = S_CFG;
      S_CFG:   w_next = S_KEY;
      S_KEY:   if (w_last_word) w_next = S_BLK;
      S_BLK:   if (w_last_word) w_next = S_START;
      S_START: w_next = S_POLL;
      S_POLL: begin
        if (w_poll_valid)   w_next = S_RD;
        else if (w_tmo_hit) w_next = S_CLR1;
      end
      S_RD:    if (w_last_word) w_next = S_CLR1;
      S_CLR1:  w_next = S_RESP;
      S_RESP:  if (rsp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_word   <= 2'd0;
      r_tmo    <= '0;
      r_encdec <= 1'b0;
      r_key    <= '0;
      r_block  <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_encdec <= cmd_encdec_i;
        r_key    <= cmd_key_i;
        r_block  <= cmd_block_i;
        r_result <= '0;
        r_error  <= 1'b0;
      end
      // The word counter wraps to 0 after each 4-word burst, ready for the next one.
      if (r_state == S_KEY || r_state == S_BLK || r_state == S_RD)
        r_word <= r_word + 2'd1;
      if (r_state == S_START)
        r_tmo <= '0;
      if (r_state == S_POLL && !w_poll_valid) begin
        r_tmo <= r_tmo + 1'b1;
        if (w_tmo_hit) r_error <= 1'b1;
      end
      if (r_state == S_RD)
        r_result[w_word_lsb +: 32] <= aes_rdata_i;
    end
  end

  // Bus decode depends on registered state and counters only.
  always_comb begin
    aes_cs_o    = 1'b0;
    aes_we_o    = 1'b0;
    aes_addr_o  = 32'd0;
    aes_wdata_o = 32'd0;
    unique case (r_state)
      S_CLR0, S_CLR1: begin
        aes_cs_o   = 1'b1;
        aes_we_o   = 1'b1;
        aes_addr_o = `ADDR_STATUS;
      end
      S_CTRL: begin
        aes_cs_o    = 1'b1;
        aes_we_o    = 1'b1;
        aes_addr_o  = `ADDR_CTRL;
        aes_wdata_o = 32'd1 << `CTRL_ON0_BIT;
      end
      S_CFG: begin
        aes_cs_o    = 1'b1;
        aes_we_o    = 1'b1;
        aes_addr_o  = `ADDR_CONFIG;
        aes_wdata_o = 32'(r_encdec) << `CTRL_ENCDEC0_BIT;
      end
      S_KEY: begin
        aes_cs_o    = 1'b1;
        aes_we_o    = 1'b1;
        aes_addr_o  = `ADDR_KEY0 + load_word_offset(r_word);
        aes_wdata_o = r_key[w_word_lsb +: 32];
      end
      S_BLK: begin
        aes_cs_o    = 1'b1;
        aes_we_o    = 1'b1;
        aes_addr_o  = `ADDR_BLOCK0 + load_word_offset(r_word);
        aes_wdata_o = r_block[w_word_lsb +: 32];
      end
      S_START: begin
        aes_cs_o    = 1'b1;
        aes_we_o    = 1'b1;
        aes_addr_o  = `ADDR_START;
        aes_wdata_o = 32'd1 << `START_BIT;
      end
      S_POLL: begin
        aes_cs_o   = 1'b1;
        aes_addr_o = `ADDR_STATUS;
      end
      S_RD: begin
        aes_cs_o   = 1'b1;
        aes_addr_o = `ADDR_RESULT0 + result_word_offset(r_word);
      end
      default: ;
    endcase
  end

  assign cmd_ready_o  = (r_state == S_IDLE) && !rst_i;
  assign busy_o       = (r_state != S_IDLE);
  assign rsp_valid_o  = (r_state == S_RESP);
  assign rsp_result_o = (r_state == S_RESP) ? r_result : 128'd0;
  assign rsp_error_o  = (r_state == S_RESP) && r_error;

endmodule

// File: tb/tb_aes_host_driver.sv
// Bench for aes_host_driver: behavioural AES register slave, bus monitor and
// directed/random commands checked against a command-level reference model.
module tb_aes_host_driver;

  localparam int T = 16;
  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_CFG    = 32'h04;
  localparam logic [31:0] A_STATUS = 32'h08;
  localparam logic [31:0] A_START  = 32'h0C;
  localparam logic [31:0] A_KEY0   = 32'h10;
  localparam logic [31:0] A_BLK0   = 32'h20;
  localparam logic [31:0] A_RES0   = 32'h30;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_encdec = 1'b0;
  logic [127:0] cmd_key = '0;
  logic [127:0] cmd_block = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_result;
  logic         rsp_error;
  logic         aes_cs, aes_we;
  logic [31:0]  aes_addr, aes_wdata, aes_rdata;
  logic         busy;

  int total = 0;
  int bad = 0;
  int viol = 0;
  acc_t log_q[$];

  always #5 clk = ~clk;

  aes_host_driver #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_encdec_i(cmd_encdec), .cmd_key_i(cmd_key), .cmd_block_i(cmd_block),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_error_o(rsp_error),
    .aes_cs_o(aes_cs), .aes_we_o(aes_we), .aes_addr_o(aes_addr),
    .aes_wdata_o(aes_wdata), .aes_rdata_i(aes_rdata), .busy_o(busy)
  );

  // Stand-in for the AES core: the FIPS-197 example pair plus a simple keyed mix otherwise.
  function automatic logic [127:0] model(input logic enc, input logic [127:0] k, input logic [127:0] b);
    if (k == K0 && enc && b == P0) return C0;
    if (k == K0 && !enc && b == C0) return P0;
    return enc ? ((k ^ b) + 128'd1) : (k ^ {b[63:0], b[127:64]});
  endfunction

  // Behavioural slave: words stored by offset, reassembled into 128-bit values at START.
  logic [31:0]  s_key [4];
  logic [31:0]  s_blk [4];
  logic         s_on = 1'b0;
  logic         s_enc = 1'b0;
  logic         s_started = 1'b0;
  int           s_poll = 0;
  logic [127:0] s_res = '0;
  int           s_delay = 0;
  logic         s_stuck = 1'b0;
  logic         s_valid;

  assign s_valid = s_started && !s_stuck && (s_poll >= s_delay);

  always @(posedge clk) begin
    if (aes_cs && aes_we) begin
      if (aes_addr == A_CTRL) s_on <= aes_wdata[0];
      else if (aes_addr == A_CFG) s_enc <= aes_wdata[0];
      else if (aes_addr == A_STATUS) s_started <= 1'b0;
      else if (aes_addr == A_START && aes_wdata[0]) begin
        s_started <= 1'b1;
        s_poll    <= 0;
        s_res     <= s_on ? model(s_enc, {s_key[0], s_key[3], s_key[2], s_key[1]},
                                  {s_blk[0], s_blk[3], s_blk[2], s_blk[1]}) : 128'd0;
      end
      else if ((aes_addr & ~32'hF) == A_KEY0) s_key[aes_addr[3:2]] <= aes_wdata;
      else if ((aes_addr & ~32'hF) == A_BLK0) s_blk[aes_addr[3:2]] <= aes_wdata;
    end else if (aes_cs && aes_addr == A_STATUS) begin
      s_poll <= s_poll + 1;
    end
  end

  always_comb begin
    aes_rdata = 32'd0;
    if (aes_addr == A_STATUS) aes_rdata = {30'd0, s_valid, 1'b1};
    else if ((aes_addr & ~32'hF) == A_RES0) begin
      case (aes_addr[3:2])
        2'd0:    aes_rdata = s_res[31:0];
        2'd1:    aes_rdata = s_res[127:96];
        2'd2:    aes_rdata = s_res[95:64];
        default: aes_rdata = s_res[63:32];
      endcase
    end
  end

  always @(negedge clk) begin
    if (aes_cs) log_q.push_back({aes_we, aes_addr, aes_we ? aes_wdata : 32'd0});
    if (aes_cs && (!busy || rsp_valid)) viol++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic enc, input logic [127:0] k,
                         input logic [127:0] b, input int delay, input logic stuck, input int hold);
    acc_t        exp_q[$];
    logic [31:0] koff [4];
    logic [31:0] roff [4];
    logic [127:0] exp_res;
    int          npoll, base, cyc, unstable, n_hold;
    koff = '{32'h0, 32'hC, 32'h8, 32'h4};
    roff = '{32'h4, 32'h8, 32'hC, 32'h0};
    s_delay = delay;
    s_stuck = stuck;
    npoll   = stuck ? T : delay + 1;
    exp_res = stuck ? 128'd0 : model(enc, k, b);

    exp_q.push_back({1'b1, A_STATUS, 32'd0});
    exp_q.push_back({1'b1, A_CTRL, 32'd1});
    exp_q.push_back({1'b1, A_CFG, {31'd0, enc}});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, A_KEY0 + koff[i], k[127-32*i -: 32]});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, A_BLK0 + koff[i], b[127-32*i -: 32]});
    exp_q.push_back({1'b1, A_START, 32'd1});
    for (int i = 0; i < npoll; i++) exp_q.push_back({1'b0, A_STATUS, 32'd0});
    if (!stuck) for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, A_RES0 + roff[i], 32'd0});
    exp_q.push_back({1'b1, A_STATUS, 32'd0});

    @(negedge clk);
    base = log_q.size();
    check({tag, " ready_idle"}, cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_encdec = enc;
    cmd_key    = k;
    cmd_block  = b;
    @(negedge clk);
    cyc = 0;
    // Garbage commands while busy must be ignored.
    while (!rsp_valid && cyc < 200) begin
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_encdec = 1'($urandom_range(0, 1));
      cmd_key    = {$urandom, $urandom, $urandom, $urandom};
      cmd_block  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    check({tag, " latency"}, cyc, stuck ? 13 + T : 17 + npoll);
    check({tag, " result"}, rsp_result, exp_res);
    check({tag, " error"}, rsp_error, stuck);
    check({tag, " busy_ready"}, {busy, cmd_ready}, 2'b10);

    unstable = 0;
    n_hold = log_q.size();
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_error !== stuck || cmd_ready !== 1'b0)
        unstable++;
    end
    check({tag, " hold_stable"}, unstable, 0);
    check({tag, " hold_nobus"}, log_q.size() - n_hold, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " back_idle"}, {busy, cmd_ready, rsp_valid}, 3'b010);

    check({tag, " bus_count"}, log_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++)
      check($sformatf("%s bus[%0d]", tag, i), log_q[base + i], exp_q[i]);
  endtask

  initial begin
    logic [127:0] rk, rb;
    @(negedge clk);
    check("reset outputs", {cmd_ready, busy, rsp_valid, rsp_error, aes_cs, aes_we}, 6'd0);
    check("reset addr_data", {aes_addr, aes_wdata, rsp_result}, '0);
    rst = 1'b0;
    #1;
    check("ready after release", cmd_ready, 1);

    run_cmd("fips_enc", 1'b1, K0, P0, 3, 1'b0, 10);
    run_cmd("fips_dec", 1'b0, K0, C0, 0, 1'b0, 0);
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      run_cmd($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), rk, rb,
              int'($urandom_range(0, 10)), 1'b0, int'($urandom_range(0, 3)));
    end
    run_cmd("timeout", 1'b1, K0, P0, 0, 1'b1, 2);

    // Reset during the third poll read.
    s_delay = 8;
    s_stuck = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_encdec = 1'b1;
    cmd_key = K0;
    cmd_block = P0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_poll bus", {aes_cs, aes_we, aes_addr}, {1'b1, 1'b0, A_STATUS});
    rst = 1'b1;
    #1;
    check("rst_poll ctl", {cmd_ready, busy, rsp_valid, rsp_error, aes_cs, aes_we}, 6'd0);
    check("rst_poll data", {aes_addr, aes_wdata, rsp_result}, '0);
    @(negedge clk);
    check("rst held ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    check("rst released", {cmd_ready, busy}, 2'b10);
    rk = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    run_cmd("after_rst", 1'b0, rk, rb, 2, 1'b0, 1);

    check("cs in idle/resp", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
